// File: rtl/pipe_type_tracker_pkg.sv
// Shared type codes, ASCII tags and RISC-V opcode constants for the
// pipeline instruction-type tracker.
package pipe_type_tracker_pkg;

   localparam int NUM_TYPES = 10;

   typedef enum logic [3:0] {
      T_R  = 4'd0,
      T_I  = 4'd1,
      T_IL = 4'd2,
      T_S  = 4'd3,
      T_B  = 4'd4,
      T_J  = 4'd5,
      T_IJ = 4'd6,
      T_U  = 4'd7,
      T_UA = 4'd8,
      T_SY = 4'd9,
      T_X  = 4'd15
   } type_code_e;

   localparam logic [15:0] TAG_R      = 16'h0052;
   localparam logic [15:0] TAG_I      = 16'h0049;
   localparam logic [15:0] TAG_IL     = 16'h494C;
   localparam logic [15:0] TAG_S      = 16'h0053;
   localparam logic [15:0] TAG_B      = 16'h0042;
   localparam logic [15:0] TAG_J      = 16'h004A;
   localparam logic [15:0] TAG_IJ     = 16'h494A;
   localparam logic [15:0] TAG_U      = 16'h0055;
   localparam logic [15:0] TAG_UA     = 16'h5541;
   localparam logic [15:0] TAG_SY     = 16'h5359;
   localparam logic [15:0] TAG_X      = 16'h0058;
   localparam logic [15:0] TAG_BUBBLE = 16'h2D2D;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/pipe_type_tracker_decode.sv
// Combinational opcode -> type-code decode for the incoming instruction and
// type-code -> ASCII tag mapping for every tracked stage.
module instr_type_decode
   import pipe_type_tracker_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int EXT_TYPES  = 0
) (
   input  logic [6:0]              opcode,
   output type_code_e              type_code,
   input  logic [NUM_STAGES-1:0]   stage_valid,
   input  logic [4*NUM_STAGES-1:0] stage_type,
   output logic [16*NUM_STAGES-1:0] stage_ascii
);

   always_comb begin
      type_code = T_X;
      case (opcode)
         OP_OP:     type_code = T_R;
         OP_IMM:    type_code = T_I;
         OP_LOAD:   type_code = T_IL;
         OP_STORE:  type_code = T_S;
         OP_BRANCH: type_code = T_B;
         OP_JAL:    type_code = T_J;
         OP_JALR:   type_code = T_IJ;
         OP_LUI:    type_code = T_U;
         OP_AUIPC:  type_code = (EXT_TYPES != 0) ? T_UA : T_X;
         OP_SYSTEM: type_code = (EXT_TYPES != 0) ? T_SY : T_X;
         default:   type_code = T_X;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_tag
         logic [15:0] tag;
         always_comb begin
            tag = TAG_X;
            case (stage_type[4*gi +: 4])
               T_R:     tag = TAG_R;
               T_I:     tag = TAG_I;
               T_IL:    tag = TAG_IL;
               T_S:     tag = TAG_S;
               T_B:     tag = TAG_B;
               T_J:     tag = TAG_J;
               T_IJ:    tag = TAG_IJ;
               T_U:     tag = TAG_U;
               T_UA:    tag = TAG_UA;
               T_SY:    tag = TAG_SY;
               default: tag = TAG_X;
            endcase
         end
         assign stage_ascii[16*gi +: 16] = stage_valid[gi] ? tag : TAG_BUBBLE;
      end
   endgenerate

endmodule

// File: rtl/pipe_type_tracker.sv
// Tracks the instruction type held by each pipeline stage (with stall/flush)
// and counts retirements per type with saturating counters.
module pipe_type_tracker
   import pipe_type_tracker_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int CNT_W      = 16,
   parameter int EXT_TYPES  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [6:0]                 opcode_in,
   input  logic [NUM_STAGES-1:0]      stall_mask,
   input  logic [NUM_STAGES-1:0]      flush_mask,
   input  logic                       cnt_clr,
   output logic [NUM_STAGES-1:0]      stage_valid,
   output logic [16*NUM_STAGES-1:0]   stage_ascii,
   output logic [NUM_TYPES*CNT_W-1:0] type_count,
   output logic [CNT_W-1:0]           total_retired
);

   logic [NUM_STAGES-1:0]   valid_reg;
   type_code_e              type_reg [NUM_STAGES];
   logic [4*NUM_STAGES-1:0] type_flat;
   type_code_e              dec_type;
   logic [CNT_W-1:0]        cnt_reg [NUM_TYPES];
   logic [CNT_W-1:0]        total_reg;
   logic                    retire;

   instr_type_decode #(
      .NUM_STAGES(NUM_STAGES),
      .EXT_TYPES (EXT_TYPES)
   ) u_decode (
      .opcode     (opcode_in),
      .type_code  (dec_type),
      .stage_valid(valid_reg),
      .stage_type (type_flat),
      .stage_ascii(stage_ascii)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg[0] <= 1'b0;
         type_reg[0]  <= T_X;
      end else if (flush_mask[0]) begin
         valid_reg[0] <= 1'b0;
      end else if (!stall_mask[0]) begin
         valid_reg[0] <= valid_in;
         type_reg[0]  <= dec_type;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < NUM_STAGES; gi++) begin : g_stage
         // Downstream capture uses the upstream registers, so a flush of
         // stage gi-1 at this edge still lets its old content move forward.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
               type_reg[gi]  <= T_X;
            end else if (flush_mask[gi]) begin
               valid_reg[gi] <= 1'b0;
            end else if (!stall_mask[gi]) begin
               if (stall_mask[gi-1]) begin
                  valid_reg[gi] <= 1'b0;
               end else begin
                  valid_reg[gi] <= valid_reg[gi-1];
                  type_reg[gi]  <= type_reg[gi-1];
               end
            end
         end
      end

      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_flat
         assign type_flat[4*gi +: 4] = type_reg[gi];
      end

      for (gi = 0; gi < NUM_TYPES; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
               cnt_reg[gi] <= '0;
            end else if (retire && (type_reg[NUM_STAGES-1] == 4'(gi)) && (cnt_reg[gi] != '1)) begin
               cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
         end
         assign type_count[CNT_W*gi +: CNT_W] = cnt_reg[gi];
      end
   endgenerate

   assign retire = valid_reg[NUM_STAGES-1] & ~stall_mask[NUM_STAGES-1] & ~flush_mask[NUM_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         total_reg <= '0;
      end else if (retire && (total_reg != '1)) begin
         total_reg <= total_reg + CNT_W'(1);
      end
   end

   assign stage_valid   = valid_reg;
   assign total_retired = total_reg;

endmodule

// File: tb/tb_pipe_type_tracker.sv
// Randomised self-checking bench: two trackers (base types / 4-bit counters and
// extended types / 16-bit counters) share stimulus and a behavioural model.
module tb_pipe_type_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [6:0]  opcode_in = '0;
   logic [4:0]  stall_mask = '0;
   logic [4:0]  flush_mask = '0;
   logic        cnt_clr = 1'b0;

   logic [4:0]   sv0, sv1;
   logic [79:0]  sa0, sa1;
   logic [39:0]  tc0;
   logic [159:0] tc1;
   logic [3:0]   tr0;
   logic [15:0]  tr1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_type_tracker #(.NUM_STAGES(5), .CNT_W(4), .EXT_TYPES(0)) dut0 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .opcode_in(opcode_in),
      .stall_mask(stall_mask), .flush_mask(flush_mask), .cnt_clr(cnt_clr),
      .stage_valid(sv0), .stage_ascii(sa0), .type_count(tc0), .total_retired(tr0));

   pipe_type_tracker #(.NUM_STAGES(5), .CNT_W(16), .EXT_TYPES(1)) dut1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .opcode_in(opcode_in),
      .stall_mask(stall_mask), .flush_mask(flush_mask), .cnt_clr(cnt_clr),
      .stage_valid(sv1), .stage_ascii(sa1), .type_count(tc1), .total_retired(tr1));

   // Model: each stage remembers the raw opcode; decoding happens only on compare.
   bit         m_valid [5];
   logic [6:0] m_op    [5];
   int         m_cnt0 [10];
   int         m_cnt1 [10];
   int         m_tot0, m_tot1;
   string      type_names [10] = '{"R", "I", "IL", "S", "B", "J", "IJ", "U", "UA", "SY"};
   logic [6:0] op_pool [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

   function automatic string type_name(logic [6:0] op, bit ext);
      case (op)
         7'b0110011: return "R";
         7'b0010011: return "I";
         7'b0000011: return "IL";
         7'b0100011: return "S";
         7'b1100011: return "B";
         7'b1101111: return "J";
         7'b1100111: return "IJ";
         7'b0110111: return "U";
         7'b0010111: return ext ? "UA" : "X";
         7'b1110011: return ext ? "SY" : "X";
         default:    return "X";
      endcase
   endfunction

   function automatic logic [15:0] exp_tag(bit v, logic [6:0] op, bit ext);
      string s;
      if (!v) return 16'h2D2D;
      s = type_name(op, ext);
      if (s.len() == 1) return {8'h00, s[0]};
      return {s[0], s[1]};
   endfunction

   function automatic int type_slot(logic [6:0] op, bit ext);
      string s = type_name(op, ext);
      for (int k = 0; k < 10; k++)
         if (type_names[k] == s) return k;
      return -1;
   endfunction

   task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(bit r, bit v, logic [6:0] op, logic [4:0] st, logic [4:0] fl, bit clr);
      bit         nv [5];
      logic [6:0] no [5];
      bit         ret;
      int         s0, s1;
      if (r) begin
         for (int i = 0; i < 5; i++) m_valid[i] = 0;
         for (int t = 0; t < 10; t++) begin m_cnt0[t] = 0; m_cnt1[t] = 0; end
         m_tot0 = 0;
         m_tot1 = 0;
         return;
      end
      ret = m_valid[4] && !st[4] && !fl[4];
      if (clr) begin
         for (int t = 0; t < 10; t++) begin m_cnt0[t] = 0; m_cnt1[t] = 0; end
         m_tot0 = 0;
         m_tot1 = 0;
      end else if (ret) begin
         s0 = type_slot(m_op[4], 1'b0);
         s1 = type_slot(m_op[4], 1'b1);
         m_tot0 = (m_tot0 + 1 > 15) ? 15 : m_tot0 + 1;
         m_tot1 = (m_tot1 + 1 > 65535) ? 65535 : m_tot1 + 1;
         if (s0 >= 0) m_cnt0[s0] = (m_cnt0[s0] + 1 > 15) ? 15 : m_cnt0[s0] + 1;
         if (s1 >= 0) m_cnt1[s1] = (m_cnt1[s1] + 1 > 65535) ? 65535 : m_cnt1[s1] + 1;
      end
      for (int i = 0; i < 5; i++) begin
         no[i] = m_op[i];
         if (fl[i])              nv[i] = 0;
         else if (st[i])         nv[i] = m_valid[i];
         else if (i == 0) begin  nv[i] = v; no[i] = op; end
         else if (st[i-1])       nv[i] = 0;
         else begin              nv[i] = m_valid[i-1]; no[i] = m_op[i-1]; end
      end
      for (int i = 0; i < 5; i++) begin m_valid[i] = nv[i]; m_op[i] = no[i]; end
   endtask

   task automatic compare_all();
      logic [4:0]   ev;
      logic [79:0]  ea0, ea1;
      logic [39:0]  ec0;
      logic [159:0] ec1;
      int           c0, c1;
      for (int i = 0; i < 5; i++) begin
         ev[i]         = m_valid[i];
         ea0[16*i +: 16] = exp_tag(m_valid[i], m_op[i], 1'b0);
         ea1[16*i +: 16] = exp_tag(m_valid[i], m_op[i], 1'b1);
      end
      for (int t = 0; t < 10; t++) begin
         c0 = m_cnt0[t];
         c1 = m_cnt1[t];
         ec0[4*t +: 4]   = c0[3:0];
         ec1[16*t +: 16] = c1[15:0];
      end
      c0 = m_tot0;
      c1 = m_tot1;
      chk("valid0", 256'(sv0), 256'(ev));
      chk("ascii0", 256'(sa0), 256'(ea0));
      chk("count0", 256'(tc0), 256'(ec0));
      chk("total0", 256'(tr0), 256'(c0[3:0]));
      chk("valid1", 256'(sv1), 256'(ev));
      chk("ascii1", 256'(sa1), 256'(ea1));
      chk("count1", 256'(tc1), 256'(ec1));
      chk("total1", 256'(tr1), 256'(c1[15:0]));
   endtask

   task automatic step(bit r, bit v, logic [6:0] op, logic [4:0] st, logic [4:0] fl, bit clr);
      rst        = r;
      valid_in   = v;
      opcode_in  = op;
      stall_mask = st;
      flush_mask = fl;
      cnt_clr    = clr;
      @(posedge clk);
      model_edge(r, v, op, st, fl, clr);
      #1;
      compare_all();
      $display("t=%0t rst=%0b v=%0b op=%b st=%b fl=%b clr=%0b ascii1=%h tot0=%0d tot1=%0d",
               $time, r, v, op, st, fl, clr, sa1, tr0, tr1);
   endtask

   initial begin
      logic [6:0] op;
      #1;
      step(1, 0, 7'h0, 5'b0, 5'b0, 0);
      step(1, 1, 7'b0110011, 5'b0, 5'b0, 0);
      // single R stream: tag walks down, first retire after edge 6
      for (int i = 0; i < 6; i++) step(0, 1, 7'b0110011, 5'b0, 5'b0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 7'h0, 5'b0, 5'b0, 0);
      // load held in stage 1 while stage 2 bubbles
      step(0, 1, 7'b0000011, 5'b0, 5'b0, 0);
      step(0, 1, 7'b0110011, 5'b0, 5'b0, 0);
      step(0, 1, 7'b0010011, 5'b00011, 5'b0, 0);
      step(0, 1, 7'b0010011, 5'b00011, 5'b0, 0);
      // flush stages 1 and 2 while stage 3 captures stage 2
      step(0, 1, 7'b0100011, 5'b0, 5'b00110, 0);
      step(0, 1, 7'b0010111, 5'b0, 5'b0, 0);
      step(0, 1, 7'b1110011, 5'b0, 5'b0, 0);
      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 9)];
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), op,
              ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0,
              ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0,
              ($urandom_range(0, 49) == 0));
      end
      // saturation with 4-bit counters: 17+ branch retirements
      step(0, 0, 7'h0, 5'b0, 5'b0, 1);
      for (int i = 0; i < 22; i++) step(0, 1, 7'b1100011, 5'b0, 5'b0, 0);
      // clear coincident with a retire
      step(0, 1, 7'b1100011, 5'b0, 5'b0, 1);
      step(0, 1, 7'b1100011, 5'b0, 5'b0, 0);
      // reset with in-flight instructions and a retire pending
      step(0, 0, 7'h0, 5'b0, 5'b0, 0);
      step(0, 0, 7'h0, 5'b0, 5'b0, 0);
      step(1, 1, 7'b0110011, 5'b0, 5'b0, 0);
      step(0, 0, 7'h0, 5'b0, 5'b0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_type_tracker.md
PIPE_TYPE_TRACKER -- requirements
Module: pipe_type_tracker

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of tracked pipeline stages (legal range 2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of every retire counter.
REQ-003 SHALL have parameter EXT_TYPES, default 0; when 1, AUIPC and SYSTEM opcodes decode to their own types.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, an instruction is offered to stage 0 this cycle.
REQ-007 SHALL have port opcode_in, input, 7, RISC-V opcode field of the offered instruction.
REQ-008 SHALL have port stall_mask, input, NUM_STAGES, bit i holds stage i.
REQ-009 SHALL have port flush_mask, input, NUM_STAGES, bit i bubbles stage i.
REQ-010 SHALL have port cnt_clr, input, 1, synchronous clear of all counters.
REQ-011 SHALL have port stage_valid, output, NUM_STAGES, bit i set when stage i holds an instruction.
REQ-012 SHALL have port stage_ascii, output, 16*NUM_STAGES, 2-char ASCII tag per stage; stage i in bits [16i+15:16i].
REQ-013 SHALL have port type_count, output, 10*CNT_W, per-type retire counters; type code t in bits [CNT_W*t+CNT_W-1:CNT_W*t].
REQ-014 SHALL have port total_retired, output, CNT_W, saturating count of all retirements.

Function
REQ-015 Decode, type code / tag: 0110011 -> 0 "R"; 0010011 -> 1 "I"; 0000011 -> 2 "IL"; 0100011 -> 3 "S"; 1100011 -> 4 "B"; 1101111 -> 5 "J"; 1100111 -> 6 "IJ"; 0110111 -> 7 "U"; 0010111 -> 8 "UA" and 1110011 -> 9 "SY" only if EXT_TYPES=1; all others -> 15 "X".
REQ-016 Single-letter tags SHALL be 0x00 in the high byte and the letter in the low byte ("R" = 0x0052); two-letter tags first char high ("IL" = 0x494C, "IJ" = 0x494A, "UA" = 0x5541, "SY" = 0x5359); "X" = 0x0058.
REQ-017 A bubble stage SHALL show stage_valid=0 and tag "--" = 0x2D2D.
REQ-018 Each stage SHALL store a valid bit and a 4-bit type code; stage_ascii and stage_valid SHALL be combinational from that stored state only.
REQ-019 Stage 0 next state, priority order: flush_mask[0] -> bubble; stall_mask[0] -> hold; valid_in -> decoded opcode_in; else bubble.
REQ-020 Stage i>=1 next state, priority order: flush_mask[i] -> bubble; stall_mask[i] -> hold; stall_mask[i-1] -> bubble inserted; else copy stage i-1.
REQ-021 Latency: with no stall/flush, an instruction accepted at edge k SHALL appear in stage j after edge k+j.
REQ-022 Retire SHALL occur at an edge when the last stage is valid and both stall_mask[NUM_STAGES-1] and flush_mask[NUM_STAGES-1] are 0.
REQ-023 On retire, type_count for that stage's type and total_retired SHALL each increment by 1, saturating at 2^CNT_W-1.
REQ-024 Retired "X" instructions SHALL count in total_retired only; no type_count slot.
REQ-025 cnt_clr SHALL zero all counters and override a simultaneous retire; stage state is unaffected.
REQ-026 Flush and stall on the same stage SHALL flush; flush of stage i SHALL NOT affect stage i+1 capturing stage i's old content at that edge.

Reset
REQ-027 rst SHALL override all inputs: every stage bubble ("--", valid 0), all counters 0, effective at the next edge.
REQ-028 rst asserted mid-operation SHALL discard in-flight instructions without counting them.

Structure
REQ-029 A shared package SHALL hold the type-code enum, ASCII tag constants, opcode constants, NUM_TYPES=10.
REQ-030 A sub-module instr_type_decode SHALL be the combinational opcode -> type-code and type-code -> tag mapping, parametrised by EXT_TYPES.
REQ-031 Slot 15 ("X") SHALL have no counter.

Verification
REQ-032 Reset then valid_in=1 with opcode 0110011, NUM_STAGES=5, no stalls -> stage 0 tag 0x0052 after edge 1, stage 4 after edge 5, type_count[0]=1 and total_retired=1 after edge 6.
REQ-033 Opcode 0000011 into stage 1 with stall_mask=5'b00011 for 2 cycles -> stages 0,1 hold; stage 2 shows 0x2D2D for 2 cycles; stage 1 keeps 0x494C.
REQ-034 flush_mask=5'b00110 with stages 1,2 valid -> both show 0x2D2D next cycle; stage 3 captures stage 2's prior tag.
REQ-035 EXT_TYPES=0 and 1, opcode 0010111 -> tag 0x0058 vs 0x5541; retire increments total_retired only vs type_count[8].
REQ-036 CNT_W=4, retire 17 "B" instructions -> type_count[4] and total_retired = 15; cnt_clr coincident with a retire -> both 0.
REQ-037 rst with 3 valid stages and a retire pending -> all stages 0x2D2D, all counters 0.
